eq_band_scheduler: RTL and testbench

//  Time-shares one multiply-accumulate (MAC) engine and one coefficient ROM between NUM_BANDS FIR bands.

---
 rtl/eq_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/eq_band_scheduler.sv | 128 ++++++++++++
 tb/tb_eq_band_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_sched_pkg.sv
// Shared types and helpers for the EQ band scheduler.
package eq_sched_pkg;

  typedef enum logic [2:0] {IDLE, ARB, RUN, DONE} sched_st_t;

  localparam int Q_SHIFT = 15;

  // Clip a signed value to the range of a dw-bit signed word.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic          found;
  logic [PW-1:0] k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = PW'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/eq_band_scheduler.sv
// Time-shares one MAC and coefficient ROM between NUM_BANDS FIR bands.
// RESULT_SAT_EN: when defined, the Q1.15 result is clipped instead of wrapped.
module eq_band_scheduler
  import eq_sched_pkg::*;
#(
  parameter int NUM_BANDS = 4,
  parameter int TAPS      = 1021,
  parameter int AW        = 10,
  parameter int DW        = 16,
  parameter int ACCW      = 40
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_BANDS-1:0] band_req,
  input  logic [DW-1:0]        smpl_in,
  input  logic                 smpl_vld,
  input  logic [DW-1:0]        coeff,
  output logic [AW-1:0]        coeff_addr,
  output logic [NUM_BANDS-1:0] grant,
  output logic [NUM_BANDS-1:0] band_done,
  output logic [DW-1:0]        band_result,
  output logic                 busy
);

  localparam int PW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int TW = $clog2(TAPS + 1);

  if (TAPS > (1 << AW)) begin : g_taps_chk
    $error("TAPS exceeds coefficient ROM depth");
  end

  sched_st_t state, state_nxt;

  logic [NUM_BANDS-1:0] gnt_q, arb_gnt;
  logic [PW-1:0]        rr_ptr, gnt_idx, arb_idx, ptr_inc;
  logic [TW-1:0]        tap_cnt;
  logic [DW-1:0]        smpl_d;
  logic                 vld_d;
  logic [ACCW-1:0]      acc, acc_nxt;
  logic [2*DW-1:0]      prod;
  logic [DW-1:0]        result_q, result_nxt;
  logic                 abort, accept, last_acc;

  rr_arbiter #(.N(NUM_BANDS), .PW(PW)) u_arb (
    .req (band_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign abort    = (state == RUN) && ((band_req & gnt_q) == '0);
  assign accept   = (state == RUN) && smpl_vld && (tap_cnt < TW'(TAPS));
  // tap_cnt already counts the sample whose product is being added
  assign last_acc = (state == RUN) && vld_d && (tap_cnt == TW'(TAPS)) && !abort;
  assign ptr_inc  = (gnt_idx == PW'(NUM_BANDS - 1)) ? '0 : gnt_idx + PW'(1);

  assign prod    = {{DW{smpl_d[DW-1]}}, smpl_d} * {{DW{coeff[DW-1]}}, coeff};
  assign acc_nxt = acc + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};

`ifdef RESULT_SAT_EN
  assign result_nxt = DW'(sat_dw($signed({{(64-ACCW){acc_nxt[ACCW-1]}}, acc_nxt}) >>> Q_SHIFT, DW));
`else
  assign result_nxt = acc_nxt[DW+Q_SHIFT-1:Q_SHIFT];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt_q    <= '0;
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      tap_cnt  <= '0;
      smpl_d   <= '0;
      vld_d    <= 1'b0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      state  <= state_nxt;
      smpl_d <= smpl_in;
      vld_d  <= accept;
      case (state)
        ARB: begin
          gnt_q   <= arb_gnt;
          gnt_idx <= arb_idx;
          acc     <= '0;
          tap_cnt <= '0;
        end
        RUN: begin
          if (abort) begin
            acc     <= '0;
            tap_cnt <= '0;
            rr_ptr  <= ptr_inc;
          end else begin
            if (accept)   tap_cnt  <= tap_cnt + TW'(1);
            if (vld_d)    acc      <= acc_nxt;
            if (last_acc) result_q <= result_nxt;
          end
        end
        DONE: begin
          rr_ptr  <= ptr_inc;
          tap_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|band_req) state_nxt = ARB;
      ARB:     state_nxt = (|band_req) ? RUN : IDLE;
      RUN: begin
        if (abort)         state_nxt = (|band_req) ? ARB : IDLE;
        else if (last_acc) state_nxt = DONE;
      end
      DONE:    state_nxt = (|band_req) ? ARB : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant       = (state == RUN)  ? gnt_q : '0;
  assign band_done   = (state == DONE) ? gnt_q : '0;
  assign band_result = result_q;
  assign busy        = (state != IDLE);
  assign coeff_addr  = AW'(tap_cnt);

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Randomised bench for eq_band_scheduler (TAPS=4 and TAPS=1021 instances).
module tb_eq_band_scheduler;

  typedef logic [15:0] smp_t [4];
  typedef struct {
    int          cyc;
    int          band;
    logic [15:0] res;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // short-run instance
  logic        rst4_n;
  logic [3:0]  req4, grant4, done4;
  logic [15:0] smpl4, coeff4, res4;
  logic        vld4, busy4;
  logic [9:0]  addr4;
  logic [15:0] rom4 [0:1023];

  // long-run instance
  logic        rstl_n;
  logic [3:0]  reql, grantl, donel;
  logic [15:0] smpll, coeffl, resl;
  logic        vldl, busyl;
  logic [9:0]  addrl;
  logic [15:0] roml [0:1023];

  eq_band_scheduler #(.NUM_BANDS(4), .TAPS(4), .AW(10), .DW(16), .ACCW(40)) dut4 (
    .clk(clk), .rst_n(rst4_n), .band_req(req4), .smpl_in(smpl4), .smpl_vld(vld4),
    .coeff(coeff4), .coeff_addr(addr4), .grant(grant4), .band_done(done4),
    .band_result(res4), .busy(busy4)
  );

  eq_band_scheduler #(.NUM_BANDS(4), .TAPS(1021), .AW(10), .DW(16), .ACCW(40)) dutl (
    .clk(clk), .rst_n(rstl_n), .band_req(reql), .smpl_in(smpll), .smpl_vld(vldl),
    .coeff(coeffl), .coeff_addr(addrl), .grant(grantl), .band_done(donel),
    .band_result(resl), .busy(busyl)
  );

  always @(posedge clk) coeff4 <= rom4[addr4];
  always @(posedge clk) coeffl <= roml[addrl];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] scale(input longint a);
    longint q;
    q = a >>> 15;
`ifdef RESULT_SAT_EN
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
`endif
    return q[15:0];
  endfunction

  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int i = 0; i < 4; i++)
      if (m[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  // reference model state for the short instance
  exp_t        sb[$];
  logic [15:0] held = 16'h0;
  logic [3:0]  mask = 4'h0;
  int          ptr  = 0;
  int          ndone_l = 0;

  initial forever begin
    @(negedge clk);
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      check("done4", done4, 4'b1 << sb[0].band);
      check("result4", res4, sb[0].res);
      held = sb[0].res;
      void'(sb.pop_front());
    end else begin
      check("done4_quiet", done4, 0);
      check("result4_hold", res4, held);
    end
    if (grant4 != 0 || done4 != 0) check("busy4", busy4, 1);
  end

  initial forever begin
    @(negedge clk);
    if (donel != 0) ndone_l++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_grant(output int g);
    g = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (grant4 != 0) begin
        for (int j = 0; j < 4; j++) if (grant4 == (4'b1 << j)) g = j;
        if (g < 0) check("grant_onehot", grant4, 0);
        return;
      end
      vld4  = 1'($urandom_range(0, 1));
      smpl4 = 16'($urandom);
    end
    check("grant_timeout", 0, 1);
  endtask

  // Streams one band window; returns at the negedge where its done is due.
  task automatic stream(input int b, input smp_t s, input int max_gap,
                        input int abort_after, input int add_band, input bit keep);
    longint sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == abort_after) begin
        vld4 = 1'b0;
        req4[b] = 1'b0;
        mask[b] = 1'b0;
        @(negedge clk);
        check("abort_grant", grant4, 0);
        ptr = (b + 1) % 4;
        return;
      end
      repeat ($urandom_range(0, max_gap)) begin
        vld4  = 1'b0;
        smpl4 = 16'($urandom);
        @(negedge clk);
        check("grant_gap", grant4, 4'b1 << b);
      end
      vld4  = 1'b1;
      smpl4 = s[i];
      sum  += longint'($signed(s[i])) * longint'($signed(rom4[i]));
      if (i == 1 && add_band >= 0) begin
        req4[add_band] = 1'b1;
        mask[add_band] = 1'b1;
      end
      if (i == 3) sb.push_back('{cyc + 2, b, scale(sum)});
      @(negedge clk);
      check("grant_run", grant4, 4'b1 << b);
    end
    vld4  = 1'($urandom_range(0, 1));
    smpl4 = 16'($urandom);
    @(negedge clk);
    vld4 = 1'b0;
    if (!keep) begin
      req4[b] = 1'b0;
      mask[b] = 1'b0;
    end
    ptr = (b + 1) % 4;
  endtask

  task automatic session();
    int   g, e, ab, add, rereq;
    bit   keep;
    smp_t s;
    rereq = 0;
    mask  = 4'($urandom_range(1, 15));
    req4  = mask;
    for (int r = 0; r < 16 && mask != 0; r++) begin
      e = rr_pick(mask, ptr);
      wait_grant(g);
      check("rr_grant", g, e);
      if (g < 0) break;
      for (int i = 0; i < 4; i++) s[i] = 16'($urandom);
      ab   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : -1;
      add  = (r < 4 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
      if (add == g) add = -1;
      keep = (rereq < 2) && ($urandom_range(0, 3) == 0);
      if (keep) rereq++;
      stream(g, s, 2, ab, add, keep);
    end
    req4 = 4'h0;
    mask = 4'h0;
    vld4 = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy4, 0);
    check("idle_grant", grant4, 0);
  endtask

  task automatic run_long(input int n, input bit gaps, output longint sum, output int last);
    sum  = 0;
    last = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 7) == 0) begin
        vldl  = 1'b0;
        smpll = 16'($urandom);
        @(negedge clk);
      end
      vldl  = 1'b1;
      smpll = 16'($urandom);
      sum  += longint'($signed(smpll)) * longint'($signed(roml[i]));
      last  = cyc;
      @(negedge clk);
    end
    vldl = 1'b0;
  endtask

  initial begin
    int     g, lastc;
    longint lsum;
    smp_t   s;

    rst4_n = 1'b0; rstl_n = 1'b0;
    req4 = 4'hF; reql = 4'h0;
    vld4 = 1'b0; vldl = 1'b0;
    smpl4 = '0; smpll = '0;
    for (int i = 0; i < 1024; i++) begin
      rom4[i] = 16'($urandom);
      roml[i] = 16'($urandom);
    end

    // reset with all bands requesting
    repeat (2) @(negedge clk);
    check("rst_grant", grant4, 0);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_result", res4, 0);
    check("rst_addr", addr4, 0);
    req4 = 4'h0;
    rst4_n = 1'b1; rstl_n = 1'b1;
    @(negedge clk);

    // round-robin from reset, band 0 re-requests during band 2
    mask = 4'b0101; req4 = mask;
    for (int i = 0; i < 4; i++) s[i] = 16'($urandom);
    wait_grant(g);
    check("rr_first", grant4, 4'b0001);
    stream(0, s, 1, -1, -1, 1'b0);
    wait_grant(g);
    check("rr_second", grant4, 4'b0100);
    stream(2, s, 1, -1, 0, 1'b0);
    wait_grant(g);
    check("rr_third", grant4, 4'b0001);
    stream(0, s, 1, -1, -1, 1'b0);
    repeat (2) @(negedge clk);

    // single band, Q1.15 half-scale coefficients
    for (int i = 0; i < 4; i++) rom4[i] = 16'h4000;
    s = '{16'd100, 16'd200, 16'd300, 16'd400};
    mask = 4'b0010; req4 = mask;
    wait_grant(g);
    check("single_grant", grant4, 4'b0010);
    stream(1, s, 0, -1, -1, 1'b0);
    check("single_done", done4, 4'b0010);
    check("single_result", res4, 16'd500);
    repeat (2) @(negedge clk);

    // overflow of the 16-bit result window
    for (int i = 0; i < 4; i++) rom4[i] = 16'h7FFF;
    s = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    mask = 4'b0001; req4 = mask;
    wait_grant(g);
    stream(0, s, 0, -1, -1, 1'b0);
`ifdef RESULT_SAT_EN
    check("ovf_result", res4, 16'h7FFF);
`else
    check("ovf_result", res4, 16'hFFF8);
`endif
    repeat (2) @(negedge clk);

    // abort band 3 after two samples, then a fresh run on band 3
    for (int i = 0; i < 1024; i++) rom4[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) s[i] = 16'($urandom);
    mask = 4'b1000; req4 = mask;
    wait_grant(g);
    check("abort_gnt_before", grant4, 4'b1000);
    stream(3, s, 0, 2, -1, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_idle", busy4, 0);
    for (int i = 0; i < 4; i++) s[i] = 16'($urandom);
    mask = 4'b1000; req4 = mask;
    wait_grant(g);
    check("abort_regrant", grant4, 4'b1000);
    stream(3, s, 1, -1, -1, 1'b0);
    repeat (2) @(negedge clk);

    for (int n = 0; n < 25; n++) session();

    // long instance: reset after 500 samples, then a full clean run
    reql = 4'b0100;
    g = 0;
    for (int k = 0; k < 20 && grantl == 0; k++) @(negedge clk);
    check("long_grant", grantl, 4'b0100);
    run_long(500, 1'b0, lsum, lastc);
    rstl_n = 1'b0;
    reql = 4'h0;
    @(negedge clk);
    check("long_rst_busy", busyl, 0);
    check("long_rst_grant", grantl, 0);
    check("long_rst_addr", addrl, 0);
    rstl_n = 1'b1;
    repeat (3) @(negedge clk);
    check("long_no_done", ndone_l, 0);
    reql = 4'b0100;
    for (int k = 0; k < 20 && grantl == 0; k++) @(negedge clk);
    check("long_regrant", grantl, 4'b0100);
    run_long(1021, 1'b1, lsum, lastc);
    check("long_done_early", donel, 0);
    vldl = 1'b1;
    @(negedge clk);
    vldl = 1'b0;
    check("long_done_cycle", cyc - lastc, 2);
    check("long_done", donel, 4'b0100);
    check("long_result", resl, scale(lsum));
    reql = 4'h0;
    repeat (3) @(negedge clk);
    check("long_done_count", ndone_l, 1);
    check("long_idle", busyl, 0);
    check("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
